decoder38_seq: RTL and testbench

Sequenced 3-to-8 one-hot decoder, the output-side counterpart of the team's 8-to-3 encoder. It accepts 3-bit codes over a valid/ready handshake and drives the matching one-hot line on `D[7:0]` for a fixed dwell time. It can optionally insert an all-zero guard gap between codes. It sits between code-producing logic (encoder outputs, counters, switch inputs) and one-hot consumers such as LED rows, select lines and mux enables.

---
 rtl/decoder38_seq_if.sv | 28 ++
 rtl/decoder38_seq.sv | 122 ++++++++++++
 tb/tb_decoder38_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/decoder38_seq_if.sv
// Code-in / one-hot-out bundle for decoder38_seq.
// The producer uses the master modport; the decoder uses the slave modport.
interface decoder38_seq_if;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] D;
  logic       out_valid;
  logic [7:0] dec_count;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready,
    input  D,
    input  out_valid,
    input  dec_count
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready,
    output D,
    output out_valid,
    output dec_count
  );
endinterface

// File: rtl/decoder38_seq.sv
// Sequenced 3-to-8 one-hot decoder: each accepted code is driven on D for HOLD cycles.
// Define DEC38_GAP_EN to insert GAP all-zero guard cycles after each hold.
module decoder38_seq #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 2
) (
  input logic            clk,
  input logic            rst_n,
  input logic            en,
  decoder38_seq_if.slave bus
);

  if (HOLD < 1 || HOLD > 255 || GAP < 1 || GAP > 255) begin : gen_param_check
    $error("decoder38_seq: HOLD and GAP must be in 1..255");
  end

  localparam logic [7:0] HoldLoad = 8'(HOLD - 1);
`ifdef DEC38_GAP_EN
  localparam logic [7:0] GapLoad = 8'(GAP - 1);
`endif

  typedef enum logic [1:0] {
    StIdle,
    StHold
`ifdef DEC38_GAP_EN
    , StGap
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic [7:0] d_q, d_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] count_q, count_d;
  logic       ready;
  logic       accept;

  // Gated by rst_n so the producer never sees ready while the block is held in reset.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      StIdle: ready = rst_n && en;
`ifdef DEC38_GAP_EN
      StHold: ready = 1'b0;
`else
      StHold: ready = rst_n && en && (cnt_q == 8'd0);
`endif
      default: ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    count_d = count_q;
    // Accepts only happen in IDLE or the last HOLD cycle, so they override the dwell step.
    if (accept) begin
      state_d = StHold;
      cnt_d   = HoldLoad;
      code_d  = bus.in_code;
      count_d = count_q + 8'd1;
    end else if (en) begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StHold: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
`ifdef DEC38_GAP_EN
            state_d = StGap;
            cnt_d   = GapLoad;
`else
            state_d = StIdle;
`endif
          end
        end
`ifdef DEC38_GAP_EN
        StGap: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = StIdle;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
    out_valid_d = (state_d == StHold);
    d_d         = out_valid_d ? (8'd1 << code_d) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      code_q      <= 3'd0;
      d_q         <= 8'd0;
      out_valid_q <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.D         = d_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dec_count = count_q;

endmodule

// File: tb/tb_decoder38_seq.sv
// Scoreboard bench for decoder38_seq: each accept pushes the expected per-cycle D values.
// Works with or without DEC38_GAP_EN defined.
module tb_decoder38_seq;
  localparam int unsigned Hold = 4;
  localparam int unsigned Gap  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  decoder38_seq_if bus ();

  decoder38_seq #(
    .HOLD(Hold),
    .GAP (Gap)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  logic [7:0] exp_cnt = 8'd0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Ready is derived from what the scoreboard still expects to see on D.
  function automatic logic exp_ready();
    if (!rst_n || !en) return 1'b0;
`ifdef DEC38_GAP_EN
    return exp_q.size() == 0;
`else
    return exp_q.size() <= 1;
`endif
  endfunction

  task automatic step(output logic acc);
    logic [2:0] c;
    logic [7:0] exp_d;
    #1;
    check_eq("in_ready", bus.in_ready, exp_ready());
    acc = bus.in_valid && exp_ready();
    c   = bus.in_code;
    @(posedge clk);
    if (rst_n && en) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
        for (int i = 0; i < Hold; i++) exp_q.push_back(8'd1 << c);
`ifdef DEC38_GAP_EN
        for (int i = 0; i < Gap; i++) exp_q.push_back(8'h00);
`endif
        exp_cnt = exp_cnt + 8'd1;
      end
    end
    @(negedge clk);
    exp_d = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check_eq("D", bus.D, exp_d);
    check_eq("out_valid", bus.out_valid, exp_d != 8'h00);
    check_eq("dec_count", bus.dec_count, exp_cnt);
    check_eq("onehot0", $onehot0(bus.D), 1'b1);
  endtask

  task automatic run(input int n);
    logic a;
    for (int i = 0; i < n; i++) begin
      bus.in_code = 3'($urandom_range(0, 7));
      step(a);
    end
  endtask

  task automatic send(input logic [2:0] c);
    logic a;
    a = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    for (int i = 0; i < 64 && !a; i++) step(a);
    if (!a) check_eq("accept_timeout", a, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_code  = 3'($urandom_range(0, 7));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with en and in_valid asserted
    en           = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd5;
    #1;
    check_eq("rst_D", bus.D, 8'h00);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_in_ready", bus.in_ready, 1'b0);
    check_eq("rst_dec_count", bus.dec_count, 8'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_hold_D", bus.D, 8'h00);
    check_eq("rst_hold_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    run(2);

    // Single decode
    send(3'd5);
    check_eq("single_D", bus.D, 8'h20);
    check_eq("single_count", bus.dec_count, 8'd1);
    run(Hold + Gap + 2);

    // Sweep all codes, each held until accepted
    for (int k = 0; k < 8; k++) send(3'(k));
    run(Hold + Gap + 2);
    check_eq("sweep_count", bus.dec_count, 8'd9);

    // Back-to-back stream with in_valid held high
    send(3'd3);
    send(3'd6);
    check_eq("b2b_D", bus.D, 8'h40);
    run(Hold + Gap + 2);

    // Stall mid-HOLD
    send(3'd2);
    run(1);
    en = 1'b0;
    run(5);
    check_eq("stall_D", bus.D, 8'h04);
    en = 1'b1;
    run(Hold + Gap + 2);

    // Asynchronous reset mid-HOLD
    send(3'd2);
    run(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_D", bus.D, 8'h00);
    check_eq("midrst_out_valid", bus.out_valid, 1'b0);
    check_eq("midrst_in_ready", bus.in_ready, 1'b0);
    check_eq("midrst_count", bus.dec_count, 8'd0);
    exp_q.delete();
    exp_cnt = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // 256 accepts wrap the counter; in_code scrambles while busy
    for (int k = 0; k < 256; k++) send(3'($urandom_range(0, 7)));
    check_eq("wrap_count", bus.dec_count, 8'd0);
    run(Hold + Gap + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
